// File: rtl/sha256_round_ctrl_if.sv
// ----------------------------------------------------------------------------
// sha256_round_ctrl_if : handshake and datapath-strobe bundle for sha256_round_ctrl
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface sha256_round_ctrl_if;
  logic       start;
  logic       first_blk;
  logic       last_blk;
  logic       abort;
  logic       ready;
  logic       busy;
  logic [3:0] word_addr;
  logic       word_rd;
  logic       sched_load;
  logic       sched_en;
  logic       round_en;
  logic [5:0] round_idx;
  logic       init_hash;
  logic       hash_update;
  logic       digest_valid;

  modport master (
    output start, first_blk, last_blk, abort,
    input  ready, busy, word_addr, word_rd, sched_load, sched_en,
           round_en, round_idx, init_hash, hash_update, digest_valid
  );

  modport slave (
    input  start, first_blk, last_blk, abort,
    output ready, busy, word_addr, word_rd, sched_load, sched_en,
           round_en, round_idx, init_hash, hash_update, digest_valid
  );
endinterface

`default_nettype wire

// File: rtl/sha256_round_ctrl.sv
// ----------------------------------------------------------------------------
// sha256_round_ctrl : sequences INIT / 64 rounds / UPDATE / DONE for one block
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sha256_round_ctrl (
  input  logic                  clk,
  input  logic                  rst,
  sha256_round_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    ROUND  = 3'd2,
    UPDATE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [6:0] LAST_ROUND = 7'd63;
  localparam logic [6:0] LOAD_WORDS = 7'd16;

  state_t     state;
  logic [6:0] cnt;
  logic       first_q;
  logic       last_q;

  // Round strobes are registered, so they are derived from the round index
  // the FSM is about to occupy rather than the one it is leaving.
  logic       enter_round;
  logic [6:0] next_t;

  always_comb begin
    enter_round = 1'b0;
    next_t      = 7'd0;
    if (!bus.abort) begin
      case (state)
        IDLE:    enter_round = bus.start && bus.ready && !bus.first_blk;
        INIT:    enter_round = 1'b1;
        ROUND: begin
          enter_round = (cnt != LAST_ROUND);
          next_t      = cnt + 7'd1;
        end
        default: enter_round = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      cnt              <= 7'd0;
      first_q          <= 1'b0;
      last_q           <= 1'b0;
      bus.ready        <= 1'b1;
      bus.busy         <= 1'b0;
      bus.word_addr    <= 4'd0;
      bus.word_rd      <= 1'b0;
      bus.sched_load   <= 1'b0;
      bus.sched_en     <= 1'b0;
      bus.round_en     <= 1'b0;
      bus.round_idx    <= 6'd0;
      bus.init_hash    <= 1'b0;
      bus.hash_update  <= 1'b0;
      bus.digest_valid <= 1'b0;
    end else begin
      bus.ready        <= 1'b0;
      bus.busy         <= 1'b0;
      bus.word_addr    <= 4'd0;
      bus.word_rd      <= 1'b0;
      bus.sched_load   <= 1'b0;
      bus.sched_en     <= 1'b0;
      bus.round_en     <= 1'b0;
      bus.round_idx    <= 6'd0;
      bus.init_hash    <= 1'b0;
      bus.hash_update  <= 1'b0;
      bus.digest_valid <= 1'b0;

      if (bus.abort) begin
        state     <= IDLE;
        cnt       <= 7'd0;
        bus.ready <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && bus.ready) begin
              first_q  <= bus.first_blk;
              last_q   <= bus.last_blk;
              cnt      <= 7'd0;
              bus.busy <= 1'b1;
              if (bus.first_blk) begin
                state         <= INIT;
                bus.init_hash <= 1'b1;
              end else begin
                state <= ROUND;
              end
            end else begin
              bus.ready <= 1'b1;
            end
          end
          INIT: begin
            state    <= ROUND;
            cnt      <= 7'd0;
            bus.busy <= 1'b1;
          end
          ROUND: begin
            bus.busy <= 1'b1;
            if (cnt == LAST_ROUND) begin
              state           <= UPDATE;
              bus.hash_update <= 1'b1;
            end else begin
              cnt <= next_t;
            end
          end
          UPDATE: begin
            cnt <= 7'd0;
            if (last_q) begin
              state            <= DONE;
              bus.busy         <= 1'b1;
              bus.digest_valid <= 1'b1;
            end else begin
              state     <= IDLE;
              bus.ready <= 1'b1;
            end
          end
          DONE: begin
            state     <= IDLE;
            bus.ready <= 1'b1;
          end
          default: begin
            state     <= IDLE;
            bus.ready <= 1'b1;
          end
        endcase

        if (enter_round) begin
          bus.round_en  <= 1'b1;
          bus.sched_en  <= 1'b1;
          bus.round_idx <= next_t[5:0];
          if (next_t < LOAD_WORDS) begin
            bus.sched_load <= 1'b1;
            bus.word_rd    <= 1'b1;
            bus.word_addr  <= next_t[3:0];
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sha256_round_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sha256_round_ctrl : directed bench with a timeline model of the controller
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sha256_round_ctrl;

  logic clk;
  logic rst;
  sha256_round_ctrl_if bus ();

  sha256_round_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Model: a block is a timeline of positions p=1.. counted from its acceptance edge.
  bit m_act = 1'b0;
  bit m_f   = 1'b0;
  bit m_l   = 1'b0;
  int m_p   = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_act = 1'b0;
      m_p   = 0;
    end else if (bus.abort) begin
      m_act = 1'b0;
      m_p   = 0;
    end else if (!m_act) begin
      if (bus.start) begin
        m_act = 1'b1;
        m_p   = 1;
        m_f   = bus.first_blk;
        m_l   = bus.last_blk;
      end
    end else begin
      m_p++;
      if (m_p > 65 + int'(m_f) + int'(m_l)) begin
        m_act = 1'b0;
        m_p   = 0;
      end
    end
  end

  function automatic logic [18:0] model_vec();
    int t;
    logic rdy, bsy, rd, sl, se, re, ih, hu, dv;
    logic [3:0] wa;
    logic [5:0] ri;
    rdy = 0; bsy = 0; rd = 0; sl = 0; se = 0; re = 0; ih = 0; hu = 0; dv = 0;
    wa = 0; ri = 0;
    if (!m_act) begin
      rdy = 1;
    end else begin
      bsy = 1;
      t = m_p - 1 - int'(m_f);
      if (m_f && m_p == 1) ih = 1;
      if (t >= 0 && t < 64) begin
        re = 1; se = 1; ri = t[5:0];
        if (t < 16) begin
          sl = 1; rd = 1; wa = t[3:0];
        end
      end
      if (m_p == 65 + int'(m_f)) hu = 1;
      if (m_l && m_p == 66 + int'(m_f)) dv = 1;
    end
    return {rdy, bsy, wa, rd, sl, se, re, ri, ih, hu, dv};
  endfunction

  function automatic logic [18:0] dut_vec();
    return {bus.ready, bus.busy, bus.word_addr, bus.word_rd, bus.sched_load, bus.sched_en,
            bus.round_en, bus.round_idx, bus.init_hash, bus.hash_update, bus.digest_valid};
  endfunction

  always @(negedge clk) begin
    chk("cycle_outputs", int'(dut_vec()), int'(model_vec()));
    chk("exclusive_strobes",
        int'($countones({bus.init_hash, bus.round_en, bus.hash_update, bus.digest_valid}) <= 1), 1);
  end

  // Observations of one block, cycle numbers relative to the acceptance edge.
  int o_init, o_upd, o_dig, o_rdy, o_nsl, o_nre, o_sl_first, o_sl_last, o_re_first;

  task automatic observe(input int max_k, input int abort_at, input bit keep_start, input bit flip);
    o_init = -1; o_upd = -1; o_dig = -1; o_rdy = -1;
    o_nsl = 0; o_nre = 0; o_sl_first = -1; o_sl_last = -1; o_re_first = -1;
    for (int k = 1; k <= max_k; k++) begin
      @(negedge clk);
      if (!keep_start) bus.start = 1'b0;
      bus.abort = 1'b0;
      if (flip && k == 1) begin
        bus.first_blk = ~bus.first_blk;
        bus.last_blk  = ~bus.last_blk;
      end
      if (bus.init_hash && o_init < 0) o_init = k;
      if (bus.hash_update && o_upd < 0) o_upd = k;
      if (bus.digest_valid && o_dig < 0) o_dig = k;
      if (bus.sched_load) begin
        o_nsl++;
        if (o_sl_first < 0) o_sl_first = k;
        o_sl_last = k;
      end
      if (bus.round_en) begin
        o_nre++;
        if (o_re_first < 0) o_re_first = k;
        if (int'(bus.round_idx) == abort_at) bus.abort = 1'b1;
      end
      if (bus.ready) begin
        o_rdy = k;
        break;
      end
    end
  endtask

  task automatic launch(input bit f, input bit l);
    bus.start     = 1'b1;
    bus.first_blk = f;
    bus.last_blk  = l;
  endtask

  initial begin
    int found;
    rst = 1'b0;
    bus.start = 1'b0; bus.first_blk = 1'b0; bus.last_blk = 1'b0; bus.abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", int'(dut_vec()), 32'h40000);
    rst = 1'b1;
    @(negedge clk);

    // Single-block message
    launch(1, 1);
    observe(80, -1, 0, 0);
    chk("single_init_at", o_init, 1);
    chk("single_round0_at", o_re_first, 2);
    chk("single_rounds", o_nre, 64);
    chk("single_sched_first", o_sl_first, 2);
    chk("single_sched_last", o_sl_last, 17);
    chk("single_sched_count", o_nsl, 16);
    chk("single_update_at", o_upd, 66);
    chk("single_digest_at", o_dig, 67);
    chk("single_ready_at", o_rdy, 68);

    // First block of two, then the second back-to-back in the first IDLE cycle
    launch(1, 0);
    observe(80, -1, 0, 0);
    chk("blk1_update_at", o_upd, 66);
    chk("blk1_digest", o_dig, -1);
    chk("blk1_ready_at", o_rdy, 67);
    launch(0, 0);
    observe(80, -1, 0, 0);
    chk("blk2_init", o_init, -1);
    chk("blk2_round0_at", o_re_first, 1);
    chk("blk2_update_at", o_upd, 65);
    chk("blk2_digest", o_dig, -1);
    chk("blk2_ready_at", o_rdy, 66);

    // Back-to-back last block whose qualifiers flip right after acceptance
    launch(0, 1);
    observe(80, -1, 0, 1);
    chk("flip_init", o_init, -1);
    chk("flip_update_at", o_upd, 65);
    chk("flip_digest_at", o_dig, 66);
    chk("flip_ready_at", o_rdy, 67);

    // start held high for the whole block
    launch(0, 0);
    observe(80, -1, 1, 0);
    bus.start = 1'b0;
    chk("hold_rounds", o_nre, 64);
    chk("hold_update_at", o_upd, 65);
    chk("hold_ready_at", o_rdy, 66);

    // Abort at t=30
    launch(1, 1);
    observe(80, 30, 0, 0);
    chk("abort_ready_at", o_rdy, 33);
    chk("abort_rounds", o_nre, 31);
    chk("abort_update", o_upd, -1);
    chk("abort_digest", o_dig, -1);
    repeat (3) @(negedge clk);

    // start together with abort in IDLE
    bus.start = 1'b1; bus.abort = 1'b1; bus.first_blk = 1'b0; bus.last_blk = 1'b0;
    @(negedge clk);
    chk("start_abort_ready", int'(bus.ready), 1);
    chk("start_abort_round_en", int'(bus.round_en), 0);
    chk("start_abort_busy", int'(bus.busy), 0);
    bus.start = 1'b0; bus.abort = 1'b0;
    @(negedge clk);
    chk("start_abort_after_round_en", int'(bus.round_en), 0);

    // Asynchronous reset mid-cycle at t=40
    launch(0, 0);
    found = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.round_en && bus.round_idx == 6'd40) begin
        found = 1;
        break;
      end
    end
    chk("reach_t40", found, 1);
    #2 rst = 1'b0;
    #1 chk("async_reset_outputs", int'(dut_vec()), 32'h40000);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    launch(0, 1);
    observe(80, -1, 0, 0);
    chk("post_reset_rounds", o_nre, 64);
    chk("post_reset_update_at", o_upd, 65);
    chk("post_reset_digest_at", o_dig, 66);
    chk("post_reset_ready_at", o_rdy, 67);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
